// File: rtl/kpg_adder_pipe.sv
// rtl/kpg_adder_pipe.sv - pipelined Kogge-Stone KPG prefix adder/subtractor with valid/ready and tag
module kpg_adder_pipe #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L  = $clog2(WIDTH);
    localparam int NG = (L + REG_EVERY - 1) / REG_EVERY;

    // KPG held as (g,p): kill=00, propagate=01, generate=10; index 0 is the carry-in seed
    logic [NG:0]        v_q, v_d, load;
    logic [WIDTH:0]     g_q [NG];
    logic [WIDTH:0]     g_d [NG];
    logic [WIDTH:0]     p_q [NG];
    logic [WIDTH:0]     p_d [NG];
    logic [WIDTH-1:0]   x_q [NG];
    logic [WIDTH-1:0]   x_d [NG];
    logic [TAG_W-1:0]   t_q [NG];
    logic [TAG_W-1:0]   t_d [NG];
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    // Upper operand wins unless it propagates; descending j reads not-yet-updated lower entries
    function automatic logic [2*WIDTH+1:0] prefix_levels(input logic [WIDTH:0] g_in,
                                                         input logic [WIDTH:0] p_in,
                                                         input int klo, input int khi);
        logic [WIDTH:0] g;
        logic [WIDTH:0] p;
        g = g_in;
        p = p_in;
        for (int k = klo; k < khi; k++) begin
            for (int j = WIDTH; j >= (1 << k); j--) begin
                g[j] = g[j] | (p[j] & g[j - (1 << k)]);
                p[j] = p[j] & p[j - (1 << k)];
            end
        end
        return {g, p};
    endfunction

    always_comb begin
        logic ld;
        load = '0;
        ld = ~v_q[NG] | out_ready;
        load[NG] = ld;
        for (int s = NG - 1; s >= 0; s--) begin
            ld = ~v_q[s] | ld;
            load[s] = ld;
        end
    end

    assign in_ready = load[0];

    always_comb begin
        logic [WIDTH-1:0]   bp;
        logic [2*WIDTH+1:0] gp;
        logic [WIDTH:0]     gf;
        logic [WIDTH:0]     pf;
        logic [WIDTH-1:0]   carry;
        logic [WIDTH-1:0]   sm;
        v_d    = v_q;
        g_d    = g_q;
        p_d    = p_q;
        x_d    = x_q;
        t_d    = t_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        tag_d  = tag_q;
        bp     = '0;
        gp     = '0;
        gf     = '0;
        pf     = '0;
        carry  = '0;
        sm     = '0;

        if (load[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                bp     = in_sub ? ~in_b : in_b;
                g_d[0] = {in_a & bp, in_sub | in_cin};
                p_d[0] = {in_a ^ bp, 1'b0};
                x_d[0] = in_a ^ bp;
                t_d[0] = in_tag;
            end
        end

        for (int s = 1; s < NG; s++) begin
            if (load[s]) begin
                v_d[s] = v_q[s-1];
                if (v_q[s-1]) begin
                    gp = prefix_levels(g_q[s-1], p_q[s-1], (s - 1) * REG_EVERY, s * REG_EVERY);
                    g_d[s] = gp[2*WIDTH+1:WIDTH+1];
                    p_d[s] = gp[WIDTH:0];
                    x_d[s] = x_q[s-1];
                    t_d[s] = t_q[s-1];
                end
            end
        end

        // Last group plus result formation; the seed fold covers a prefix that still propagates
        if (load[NG]) begin
            v_d[NG] = v_q[NG-1];
            if (v_q[NG-1]) begin
                gp     = prefix_levels(g_q[NG-1], p_q[NG-1], (NG - 1) * REG_EVERY, L);
                gf     = gp[2*WIDTH+1:WIDTH+1];
                pf     = gp[WIDTH:0];
                carry  = gf[WIDTH:1] | (pf[WIDTH:1] & {WIDTH{gf[0]}});
                sm     = x_q[NG-1] ^ {carry[WIDTH-2:0], gf[0]};
                sum_d  = sm;
                cout_d = carry[WIDTH-1];
                ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];
                zero_d = ~|sm;
                tag_d  = t_q[NG-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int s = 0; s < NG; s++) begin
                g_q[s] <= '0;
                p_q[s] <= '0;
                x_q[s] <= '0;
                t_q[s] <= '0;
            end
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            tag_q  <= '0;
        end else begin
            v_q    <= v_d;
            g_q    <= g_d;
            p_q    <= p_d;
            x_q    <= x_d;
            t_q    <= t_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            tag_q  <= tag_d;
        end
    end

    assign out_valid = v_q[NG];
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_kpg_adder_pipe.sv
// tb/tb_kpg_adder_pipe.sv - scoreboard bench for kpg_adder_pipe
module tb_kpg_adder_pipe;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [31:0] out_sum;
    logic [3:0]  out_tag;

    logic        sw_valid, sw_cin, sw_sub;
    logic [63:0] sw_a, sw_b;
    logic [3:0]  sw_tag;
    logic        rdy16, r16_valid, r16_cout, r16_ovf, r16_zero;
    logic [15:0] r16_sum;
    logic [3:0]  r16_tag;
    logic        rdy64, r64_valid, r64_cout, r64_ovf, r64_zero;
    logic [63:0] r64_sum;
    logic [3:0]  r64_tag;

    always #5 clk = ~clk;

    kpg_adder_pipe #(.WIDTH(32), .REG_EVERY(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag));

    kpg_adder_pipe #(.WIDTH(16), .REG_EVERY(4), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy16),
        .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_cin(sw_cin), .in_sub(sw_sub), .in_tag(sw_tag),
        .out_valid(r16_valid), .out_ready(1'b1), .out_sum(r16_sum),
        .out_cout(r16_cout), .out_ovf(r16_ovf), .out_zero(r16_zero), .out_tag(r16_tag));

    kpg_adder_pipe #(.WIDTH(64), .REG_EVERY(1), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy64),
        .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub), .in_tag(sw_tag),
        .out_valid(r64_valid), .out_ready(1'b1), .out_sum(r64_sum),
        .out_cout(r64_cout), .out_ovf(r64_ovf), .out_zero(r64_zero), .out_tag(r64_tag));

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [3:0]  tag;
    } res_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_out = 0;
    res_t sb[$];
    res_t e_mon;

    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input logic [3:0] tag);
        logic [64:0] s;
        logic [63:0] mask, am, bp;
        res_t r;
        mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am     = a & mask;
        bp     = (sub ? ~b : b) & mask;
        s      = {1'b0, am} + {1'b0, bp} + {64'd0, sub | cin};
        r.sum  = s[63:0] & mask;
        r.cout = s[w];
        r.ovf  = (am[w-1] == bp[w-1]) && (r.sum[w-1] != am[w-1]);
        r.zero = (r.sum == 64'd0);
        r.tag  = tag;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                sb.push_back(model(32, {32'd0, in_a}, {32'd0, in_b}, in_cin, in_sub, in_tag));
            if (out_valid && out_ready) begin
                n_out++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got sum=%h tag=%h, required no output", out_sum, out_tag);
                end else begin
                    e_mon = sb.pop_front();
                    if ({out_sum, out_cout, out_ovf, out_zero, out_tag} !==
                        {e_mon.sum[31:0], e_mon.cout, e_mon.ovf, e_mon.zero, e_mon.tag}) begin
                        n_fail++;
                        $display("FAIL sb_result: got sum=%h c=%b v=%b z=%b tag=%h, required sum=%h c=%b v=%b z=%b tag=%h",
                                 out_sum, out_cout, out_ovf, out_zero, out_tag,
                                 e_mon.sum[31:0], e_mon.cout, e_mon.ovf, e_mon.zero, e_mon.tag);
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input logic [3:0] tag, output int waited);
        logic acc;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
        in_valid = 1'b1;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end
    endtask

    task automatic check_latency(input string name);
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            n_cmp++;
            if (out_valid !== (k == LAT)) begin
                n_fail++;
                $display("FAIL %s_latency: out_valid=%b at cycle %0d, required %b", name, out_valid, k, k == LAT);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sw_valid = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
        sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_tag = '0;
        #12;
        n_cmp++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b z=%b tag=%h, required all 0",
                     out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        int w;
        out_ready = 1'b1;
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd5, w);
        check_latency("wrap");
        n_cmp++;
        if ({out_sum, out_cout, out_ovf, out_zero, out_tag} !== {32'd0, 1'b1, 1'b0, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL wrap_value: got sum=%h c=%b v=%b z=%b tag=%h, required 0 1 0 1 5",
                     out_sum, out_cout, out_ovf, out_zero, out_tag);
        end
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 4'd6, w);
        send(32'd5, 32'd7, 1'b1, 1'b1, 4'd7, w);
        repeat (LAT + 1) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL directed_drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int w, tot, n0;
        out_ready = 1'b1;
        n0 = n_out;
        tot = 0;
        for (int i = 0; i < 100; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i), w);
            tot += w;
        end
        n_cmp++;
        if (tot != 100) begin
            n_fail++;
            $display("FAIL b2b_accept_cycles: got %0d, required 100", tot);
        end
        repeat (LAT) @(posedge clk);
        #1;
        n_cmp++;
        if (n_out - n0 != 100) begin
            n_fail++;
            $display("FAIL b2b_throughput: got %0d results, required 100", n_out - n0);
        end
    endtask

    task automatic test_stall();
        int acc, n0;
        logic a;
        logic [40:0] snap;
        out_ready = 1'b0;
        acc = 0;
        in_a = $urandom; in_b = $urandom; in_cin = 1'b1; in_sub = 1'b0; in_tag = 4'd0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk);
            #1;
            if (a) begin
                acc++;
                in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1)); in_tag = 4'(acc);
            end
        end
        n_cmp++;
        if (acc != LAT) begin
            n_fail++;
            $display("FAIL stall_accepted: got %0d, required %0d", acc, LAT);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready: got %b, required 0", in_ready);
        end
        snap = {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag};
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag} !== snap || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_stable: got %h, required %h with valid", 
                     {out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag}, snap);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pass_through: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_occupancy: in_ready=%b, required 0", in_ready);
        end
        n0 = n_out;
        out_ready = 1'b1;
        repeat (LAT + 1) @(posedge clk);
        #1;
        n_cmp++;
        if (n_out - n0 != LAT || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d results %0d left, required %0d results 0 left",
                     n_out - n0, sb.size(), LAT);
        end
    endtask

    task automatic test_reset_midflight();
        int w, n0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, 4'(9 + i), w);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_preload: out_valid=%b, required 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_sum, out_tag} !== 37'd0) begin
            n_fail++;
            $display("FAIL midrst_async: got v=%b sum=%h tag=%h, required 0", out_valid, out_sum, out_tag);
        end
        sb.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (LAT + 3) @(posedge clk);
        #1;
        n_cmp++;
        if (n_out != n0) begin
            n_fail++;
            $display("FAIL midrst_stale: got %0d results, required 0", n_out - n0);
        end
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 4'hC, w);
        check_latency("midrst");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_sweep();
        logic [63:0] ca [7];
        logic [63:0] cb [7];
        logic [1:0]  cc [7];
        res_t e16, e64;
        ca = '{64'd0, '1, '1, 64'd0, '1, 64'd5, 64'h8000_0000_0000_8000};
        cb = '{64'd0, '1, '1, 64'd0, 64'd1, 64'd5, 64'd1};
        cc = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11, 2'b10};
        for (int i = 0; i < 7; i++) begin
            sw_a = ca[i]; sw_b = cb[i]; sw_sub = cc[i][1]; sw_cin = cc[i][0]; sw_tag = 4'(i);
            sw_valid = 1'b1;
            e16 = model(16, ca[i], cb[i], cc[i][0], cc[i][1], 4'(i));
            e64 = model(64, ca[i], cb[i], cc[i][0], cc[i][1], 4'(i));
            n_cmp++;
            if ((rdy16 & rdy64) !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_ready: got %b%b, required 11", rdy16, rdy64);
            end
            @(posedge clk);
            #1;
            sw_valid = 1'b0;
            for (int k = 1; k <= 7; k++) begin
                if (k > 1) begin
                    @(posedge clk);
                    #1;
                end
                n_cmp++;
                if (r16_valid !== (k == 2) || r64_valid !== (k == 7)) begin
                    n_fail++;
                    $display("FAIL sweep_valid%0d: cycle %0d got v16=%b v64=%b", i, k, r16_valid, r64_valid);
                end
                if (k == 2) begin
                    n_cmp++;
                    if ({r16_sum, r16_cout, r16_ovf, r16_zero, r16_tag} !==
                        {e16.sum[15:0], e16.cout, e16.ovf, e16.zero, e16.tag}) begin
                        n_fail++;
                        $display("FAIL sweep16_%0d: got %h %b%b%b, required %h %b%b%b", i, r16_sum,
                                 r16_cout, r16_ovf, r16_zero, e16.sum[15:0], e16.cout, e16.ovf, e16.zero);
                    end
                end
                if (k == 7) begin
                    n_cmp++;
                    if ({r64_sum, r64_cout, r64_ovf, r64_zero, r64_tag} !==
                        {e64.sum, e64.cout, e64.ovf, e64.zero, e64.tag}) begin
                        n_fail++;
                        $display("FAIL sweep64_%0d: got %h %b%b%b, required %h %b%b%b", i, r64_sum,
                                 r64_cout, r64_ovf, r64_zero, e64.sum, e64.cout, e64.ovf, e64.zero);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/kpg_adder_pipe.md
Name: kpg_adder_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational KPG (kill/propagate/generate) prefix adder used in the IFU.
- Computes A+B+cin or A−B on a Kogge-Stone KPG prefix tree of configurable width.
- Pipeline registers are inserted every REG_EVERY prefix levels, with valid/ready flow control and a sideband tag.
- Feeds the IFU next-PC / branch-target path and any other consumer that needs a wide add at higher clock rates.

Parameters:
- WIDTH, 32: operand width; power of two, ≥4.
- REG_EVERY, 2: prefix levels per pipeline stage; 1..log2(WIDTH).
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  0: A+B+cin; 1: A−B.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result bits.
- out_cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_sum == 0.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset: asynchronous, active-high. All stage valid bits clear immediately, and all data/tag registers go to 0. Outputs under reset: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0, out_tag=0. in_ready=1 once rst deasserts.
- Handshake: a transfer occurs when valid&&ready is sampled on a rising clk edge. Inputs are sampled only on an accepted transfer. out_* stay stable while out_valid=1 && out_ready=0.
- KPG encoding:
  - Per bit: kill = ~a&~b', generate = a&b', propagate = otherwise.
  - b' = in_sub ? ~in_b : in_b.
  - Position −1 seeds the tree with generate if (in_sub | in_cin), else kill.
  - Combine rule: the upper operand wins unless it is propagate, in which case the lower operand is passed. This is the same operator as the existing adder.
- Tree: L = log2(WIDTH) Kogge-Stone levels, with level k spanning distance 2^(k−1). Positions below the span pass through unchanged.
- Pipeline structure:
  - Stage 0 registers the generated KPG vector, a^b', sub and tag.
  - One register stage follows every REG_EVERY levels, the last group possibly shorter.
  - The final stage registers sum, cout, ovf, zero and tag.
  - Latency LAT = ceil(L/REG_EVERY) + 1 cycles from acceptance to out_valid. Example: WIDTH=32, REG_EVERY=2 gives LAT=4.
- Result formation (final stage):
  - out_sum[i] = (a^b')[i] ^ carry[i−1], where carry = resolved prefix is generate.
  - out_cout = carry[WIDTH−1].
  - out_ovf = carry[WIDTH−1] ^ carry[WIDTH−2].
  - out_zero = ~|out_sum.
- Flow control:
  - Each stage holds a valid bit. A stage loads when it is empty or when its successor loads in the same cycle. The last stage "loads onward" when out_ready=1.
  - in_ready = stage 0 can load. This is combinational from out_ready through the stage valids; there is no combinational path from in_valid.
  - Sustained throughput is 1 op/cycle with out_ready=1. Bubbles collapse when downstream stalls.
- Boundary cases:
  - Full pipeline with out_ready=0: in_ready=0 and nothing is lost or duplicated.
  - Simultaneous accept and output handshake on a full pipeline: both occur, and occupancy is unchanged.
  - Wrap-around: sums are modulo 2^WIDTH, with the carry reported in out_cout.
  - rst asserted mid-operation: all in-flight ops are discarded and none emerge after deassertion.
  - in_cin is ignored when in_sub=1.

Test Plan:
1. WIDTH=32, REG_EVERY=2: in_a=0xFFFF_FFFF, in_b=1, cin=0, sub=0, tag=5 → after 4 cycles out_sum=0, cout=1, ovf=0, zero=1, tag=5.
2. in_a=0x7FFF_FFFF, in_b=1, sub=0 → sum=0x8000_0000, ovf=1, cout=0. Then in_a=5, in_b=7, sub=1 → sum=0xFFFF_FFFE, cout=0, ovf=0.
3. Back-to-back stream of 100 random ops, out_ready=1 → one result per cycle, in order, tags intact, every result matches the reference model (a + (sub?~b:b) + (sub|cin)).
4. out_ready held 0 while feeding ops → exactly LAT ops are accepted, then in_ready=0 and outputs stay stable. Release out_ready → all ops drain in order with no loss.
5. Assert rst with 3 ops in flight → out_valid=0 immediately (asynchronous). After deassertion, no stale results appear and the next op completes in LAT cycles.
6. Parameter sweep: WIDTH=16/REG_EVERY=4 (LAT=2) and WIDTH=64/REG_EVERY=1 (LAT=7) → exhaustive-corner ops (0+0, max+max, cin=1) match the reference model.
